// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
//   - width_ok():    legality of a SIZE/STAGES pair; the top refuses to elaborate otherwise.
//   - slice_width(): bits handled by one pipeline slice (C = SIZE/STAGES).
//   - stage_t:       payload carried by one pipeline stage in the default build.
package pipelined_adder_pkg;

    localparam int DEF_SIZE   = 16;
    localparam int DEF_STAGES = 4;

    function automatic bit width_ok(input int size, input int stages);
        return (stages >= 1) && (stages <= size) && ((size % stages) == 0);
    endfunction

    function automatic int slice_width(input int size, input int stages);
        return size / stages;
    endfunction

    localparam int DEF_C = slice_width(DEF_SIZE, DEF_STAGES);

    // Valid bit, carry into the next slice, the slice's partial sum and the
    // operand slices that have not been consumed yet.
    typedef struct packed {
        logic                      valid;
        logic                      carry;
        logic [DEF_C-1:0]          psum;
        logic [DEF_SIZE-DEF_C-1:0] rem_a;
        logic [DEF_SIZE-DEF_C-1:0] rem_b;
    } stage_t;

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle of the pipelined adder.
//   master: operand producer and result consumer (drives in_valid, a, b, cin, sub, out_ready)
//   slave:  the adder (drives in_ready, out_valid, s, cout, ovf)
interface pipelined_adder_if
    import pipelined_adder_pkg::*;
#(
    parameter int SIZE = DEF_SIZE
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            cin;
    logic            sub;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] s;
    logic            cout;
    logic            ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder_adder_slice.sv
// One C-bit registered slice of the pipelined adder.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance (low while the pipeline is stalled)
//   a, b, cin  : operand slice pair and carry-in
//   sum        : registered partial sum
//   cout       : registered carry-out of the slice
//   msb_cin    : registered carry into the slice MSB (signed overflow on the top slice)
module adder_slice
    import pipelined_adder_pkg::*;
#(
    parameter int C = DEF_C
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [C-1:0] a,
    input  logic [C-1:0] b,
    input  logic         cin,
    output logic [C-1:0] sum,
    output logic         cout,
    output logic         msb_cin
);
    logic [C:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, cin};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum     <= '0;
            cout    <= 1'b0;
            msb_cin <= 1'b0;
        end else if (en) begin
            sum     <= full[C-1:0];
            cout    <= full[C];
            // Carry into bit C-1 falls out of the sum bit: s = a ^ b ^ c.
            msb_cin <= full[C-1] ^ a[C-1] ^ b[C-1];
        end
    end
endmodule

// File: rtl/pipelined_adder.sv
// Fully pipelined SIZE-bit add/subtract unit, STAGES slices of C = SIZE/STAGES bits.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of pipelined_adder_if (operands in, result out)
// Result: {cout, s} = a + (sub ? ~b : b) + cin; ovf flags signed overflow.
//
// Handshake: an operand set transfers on a rising edge where in_valid && in_ready,
// a result transfers where out_valid && out_ready. The whole pipeline stalls as a
// unit while out_valid && !out_ready, so in_ready = !stall is the only path from
// an input to an output. Bubbles advance when not stalled and only collapse at
// the output.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int SIZE   = DEF_SIZE,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_adder_if.slave bus
);
    localparam int C = slice_width(SIZE, STAGES);

    if (!width_ok(SIZE, STAGES)) begin : g_bad_width
        $error("pipelined_adder: SIZE must be a multiple of STAGES with 1 <= STAGES <= SIZE");
    end

    logic            stall;
    logic [SIZE-1:0] b_eff;
    logic [SIZE-1:0] s_q;
    logic            out_valid_q;
    logic            cout_q;
    logic            msb_cin_q;

    assign b_eff = bus.sub ? ~bus.b : bus.b;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        logic [C-1:0] op_a;
        logic [C-1:0] op_b;
        logic [C-1:0] psum;
        logic         c_in;
        logic         c_out;
        logic         msb_cin;
        logic         valid_d;
        logic         valid_q;

        if (k == 0) begin : g_src
            assign op_a    = bus.a[C-1:0];
            assign op_b    = b_eff[C-1:0];
            assign c_in    = bus.cin;
            // While not stalled in_ready is 1, so in_valid alone marks a transfer.
            assign valid_d = bus.in_valid;
        end else begin : g_src
            assign op_a    = g_stage[k-1].g_skew.rem_a[C-1:0];
            assign op_b    = g_stage[k-1].g_skew.rem_b[C-1:0];
            assign c_in    = g_stage[k-1].c_out;
            assign valid_d = g_stage[k-1].valid_q;
        end

        adder_slice #(.C(C)) u_slice (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (!stall),
            .a       (op_a),
            .b       (op_b),
            .cin     (c_in),
            .sum     (psum),
            .cout    (c_out),
            .msb_cin (msb_cin)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
            end else if (!stall) begin
                valid_q <= valid_d;
            end
        end

        // Skew: operand bits for the slices above this one, delayed so each
        // slice meets its operands in the same cycle as its carry.
        if (k < STAGES - 1) begin : g_skew
            localparam int R = SIZE - (k + 1) * C;
            logic [R-1:0] rem_a;
            logic [R-1:0] rem_b;
            logic [R-1:0] nxt_a;
            logic [R-1:0] nxt_b;

            if (k == 0) begin : g_nxt
                assign nxt_a = bus.a[SIZE-1:C];
                assign nxt_b = b_eff[SIZE-1:C];
            end else begin : g_nxt
                assign nxt_a = g_stage[k-1].g_skew.rem_a[R+C-1:C];
                assign nxt_b = g_stage[k-1].g_skew.rem_b[R+C-1:C];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rem_a <= '0;
                    rem_b <= '0;
                end else if (!stall) begin
                    rem_a <= nxt_a;
                    rem_b <= nxt_b;
                end
            end
        end

        // Deskew: finished lower result slices ride along with the operation.
        if (k > 0) begin : g_lo
            logic [k*C-1:0] sum_lo;
            logic [k*C-1:0] nxt_lo;

            if (k == 1) begin : g_nxt
                assign nxt_lo = g_stage[0].psum;
            end else begin : g_nxt
                assign nxt_lo = {g_stage[k-1].psum, g_stage[k-1].g_lo.sum_lo};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_lo <= '0;
                end else if (!stall) begin
                    sum_lo <= nxt_lo;
                end
            end
        end
    end

    if (STAGES == 1) begin : g_out
        assign s_q = g_stage[0].psum;
    end else begin : g_out
        assign s_q = {g_stage[STAGES-1].psum, g_stage[STAGES-1].g_lo.sum_lo};
    end

    assign out_valid_q = g_stage[STAGES-1].valid_q;
    assign cout_q      = g_stage[STAGES-1].c_out;
    assign msb_cin_q   = g_stage[STAGES-1].msb_cin;

    assign stall        = out_valid_q && !bus.out_ready;
    assign bus.in_ready = !stall;
    assign bus.out_valid = out_valid_q;

    // Bubbles left behind a result still hold data; present zeros when idle.
    assign bus.s    = out_valid_q ? s_q : '0;
    assign bus.cout = out_valid_q && cout_q;
    // Signed overflow: carry into the MSB differs from carry out of it.
    assign bus.ovf  = out_valid_q && (cout_q ^ msb_cin_q);
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: four instances (STAGES = 4, 1, 2, 16, SIZE = 16)
// share one stimulus stream; each keeps its own expected queue fed from a
// 17-bit arithmetic reference.
module tb_pipelined_adder;
    localparam int W  = 16;
    localparam int ND = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid;
    logic         cin;
    logic         sub;
    logic         out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic [ND-1:0] rdy_v;
    logic [ND-1:0] ov_v;
    logic [ND-1:0] co_v;
    logic [ND-1:0] of_v;
    logic [W-1:0]  so [ND];
    int            pend [ND];

    int checks = 0;
    int errors = 0;

    function automatic int st_of(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 2;
            default: return 16;
        endcase
    endfunction

    // {ovf, cout, s} straight from the arithmetic definition.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic rc, input logic rs);
        logic [W-1:0] be;
        logic [W:0]   wide;
        logic         ov;
        be   = rs ? ~rb : rb;
        wide = {1'b0, ra} + {1'b0, be} + {{W{1'b0}}, rc};
        ov   = (ra[W-1] == be[W-1]) && (wide[W-1] != ra[W-1]);
        return {ov, wide[W], wide[W-1:0]};
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int ST = st_of(g);
        pipelined_adder_if #(.SIZE(W)) bus ();
        logic [W+1:0] exp_q [$];
        logic [W+1:0] got;
        logic [W+1:0] exp;

        assign bus.in_valid  = in_valid;
        assign bus.a         = a;
        assign bus.b         = b;
        assign bus.cin       = cin;
        assign bus.sub       = sub;
        assign bus.out_ready = out_ready;
        assign rdy_v[g]      = bus.in_ready;
        assign ov_v[g]       = bus.out_valid;
        assign co_v[g]       = bus.cout;
        assign of_v[g]       = bus.ovf;
        assign so[g]         = bus.s;

        pipelined_adder #(.SIZE(W), .STAGES(ST)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );

        // Scoreboard: sampled mid-cycle, each handshake seen here completes on the next rising edge.
        always @(negedge clk) begin
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    got = {bus.ovf, bus.cout, bus.s};
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_extra st=%0d: got {ovf,cout,s}=%h, required no result", ST, got);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL sb_data st=%0d: got {ovf,cout,s}=%h, required %h", ST, got, exp);
                        end
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(ref_op(bus.a, bus.b, bus.cin, bus.sub));
                end
            end
            pend[g] = exp_q.size();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_op();
        a   = W'($urandom_range(0, 65535));
        b   = W'($urandom_range(0, 65535));
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic check_drained(input string name);
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (pend[i] != 0) begin
                errors++;
                $display("FAIL %s_lost st=%0d: got %0d results outstanding, required 0", name, st_of(i), pend[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rdy_v !== {ND{1'b1}}) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required %b", rdy_v, {ND{1'b1}});
        end
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (ov_v[i] !== 1'b0 || so[i] !== '0 || co_v[i] !== 1'b0 || of_v[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs st=%0d: got valid=%b s=%h cout=%b ovf=%b, required all 0",
                         st_of(i), ov_v[i], so[i], co_v[i], of_v[i]);
            end
        end
        tick();
    endtask

    task automatic test_directed(input string name, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic cc, input logic ss,
                                 input logic [W-1:0] es, input logic ec, input logic eo);
        logic [ND-1:0] seen;
        seen      = '0;
        out_ready = 1'b1;
        a = aa; b = bb; cin = cc; sub = ss;
        in_valid  = 1'b1;
        #1;
        checks++;
        if (rdy_v !== {ND{1'b1}}) begin
            errors++;
            $display("FAIL %s_ready: got %b, required %b", name, rdy_v, {ND{1'b1}});
        end
        tick();
        in_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            for (int i = 0; i < ND; i++) begin
                if (ov_v[i]) begin
                    checks++;
                    if (seen[i] || n != st_of(i)) begin
                        errors++;
                        $display("FAIL %s_latency st=%0d: got out_valid at cycle %0d, required only at cycle %0d",
                                 name, st_of(i), n, st_of(i));
                    end
                    seen[i] = 1'b1;
                    checks++;
                    if ({of_v[i], co_v[i], so[i]} !== {eo, ec, es}) begin
                        errors++;
                        $display("FAIL %s_value st=%0d: got s=%h cout=%b ovf=%b, required s=%h cout=%b ovf=%b",
                                 name, st_of(i), so[i], co_v[i], of_v[i], es, ec, eo);
                    end
                end
            end
            tick();
        end
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (!seen[i]) begin
                errors++;
                $display("FAIL %s_timeout st=%0d: got no result in 20 cycles, required one", name, st_of(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        int first [ND];
        int last  [ND];
        int cnt   [ND];
        for (int i = 0; i < ND; i++) begin
            first[i] = -1; last[i] = -1; cnt[i] = 0;
        end
        out_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            if (n < 8) begin
                rand_op();
                in_valid = 1'b1;
                #1;
                checks++;
                if (rdy_v !== {ND{1'b1}}) begin
                    errors++;
                    $display("FAIL b2b_in_ready cycle %0d: got %b, required %b", n, rdy_v, {ND{1'b1}});
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            for (int i = 0; i < ND; i++) begin
                if (ov_v[i]) begin
                    if (first[i] < 0) first[i] = n;
                    last[i] = n;
                    cnt[i]++;
                end
            end
            tick();
        end
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (cnt[i] != 8 || (last[i] - first[i] + 1) != 8 || first[i] != st_of(i)) begin
                errors++;
                $display("FAIL b2b_stream st=%0d: got %0d results over cycles %0d..%0d, required 8 over %0d..%0d",
                         st_of(i), cnt[i], first[i], last[i], st_of(i), st_of(i) + 7);
            end
        end
        check_drained("b2b");
    endtask

    task automatic test_stall();
        logic [W-1:0]  hold_s [ND];
        logic [ND-1:0] hold_c;
        logic [ND-1:0] hold_o;
        out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            rand_op();
            in_valid = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        rand_op();
        in_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++;
            if (rdy_v !== '0 || ov_v !== {ND{1'b1}}) begin
                errors++;
                $display("FAIL stall_flags cycle %0d: got in_ready=%b out_valid=%b, required %b and %b",
                         n, rdy_v, ov_v, {ND{1'b0}}, {ND{1'b1}});
            end
            if (n == 0) begin
                for (int i = 0; i < ND; i++) hold_s[i] = so[i];
                hold_c = co_v;
                hold_o = of_v;
            end else begin
                for (int i = 0; i < ND; i++) begin
                    checks++;
                    if (so[i] !== hold_s[i] || co_v[i] !== hold_c[i] || of_v[i] !== hold_o[i]) begin
                        errors++;
                        $display("FAIL stall_hold st=%0d: got s=%h cout=%b ovf=%b, required s=%h cout=%b ovf=%b",
                                 st_of(i), so[i], co_v[i], of_v[i], hold_s[i], hold_c[i], hold_o[i]);
                    end
                end
            end
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (25) tick();
        check_drained("stall");
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            rand_op();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        for (int i = 0; i < ND; i++) begin
            checks++;
            if (ov_v[i] !== 1'b0 || so[i] !== '0) begin
                errors++;
                $display("FAIL midreset_clear st=%0d: got valid=%b s=%h, required valid=0 s=0000",
                         st_of(i), ov_v[i], so[i]);
            end
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            checks++;
            if (ov_v !== '0) begin
                errors++;
                $display("FAIL midreset_stale cycle %0d: got out_valid=%b, required 0", n, ov_v);
            end
            tick();
        end
        check_drained("midreset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            rand_op();
            in_valid = ($urandom_range(0, 4) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) tick();
        check_drained("random");
    endtask

    initial begin
        test_reset();
        test_directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        test_directed("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        test_directed("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        test_directed("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        test_directed("sub_nocin", 16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
        test_back_to_back();
        test_stall();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
